// File: rtl/path_sensor_filter.sv
// Line-sensor conditioning: 2-flop synchroniser, per-channel debounce,
// pattern-change strobe and lost-track detection for the line-tracing path.
module path_sensor_filter #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned DB_W            = 16,
  parameter int unsigned LOST_CYCLES     = 25000000,
  parameter int unsigned LOST_W          = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] sensor_raw,
  output logic [3:0] PathDectSignal,
  output logic       path_changed,
  output logic       track_lost
);

  localparam int unsigned NUM_CH = 4;
  localparam logic [DB_W-1:0]   DB_MAX   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LOST_W-1:0] LOST_MAX = LOST_W'(LOST_CYCLES - 1);
  localparam logic [3:0]        NO_LINE  = 4'b1111;

  logic [NUM_CH-1:0]           s1;
  logic [NUM_CH-1:0]           s2;
  logic [NUM_CH-1:0][DB_W-1:0] db_cnt;
  logic [NUM_CH-1:0][DB_W-1:0] db_cnt_nxt;
  logic [NUM_CH-1:0]           path_nxt;
  logic [LOST_W-1:0]           lost_cnt;
  logic [LOST_W-1:0]           lost_cnt_nxt;
  logic                        track_lost_nxt;

  // Per-channel debounce: a level is accepted only after DEBOUNCE_CYCLES
  // consecutive cycles of disagreement with the current accepted level.
  always_comb begin
    db_cnt_nxt = db_cnt;
    path_nxt   = PathDectSignal;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s2[i] == PathDectSignal[i]) begin
        db_cnt_nxt[i] = '0;
      end else if (db_cnt[i] == DB_MAX) begin
        db_cnt_nxt[i] = '0;
        path_nxt[i]   = s2[i];
      end else begin
        db_cnt_nxt[i] = db_cnt[i] + DB_W'(1);
      end
    end
  end

  // Lost-track timer runs on the registered pattern and saturates.
  always_comb begin
    lost_cnt_nxt   = lost_cnt;
    track_lost_nxt = track_lost;
    if (PathDectSignal == NO_LINE) begin
      if (lost_cnt == LOST_MAX) begin
        track_lost_nxt = 1'b1;
      end else begin
        lost_cnt_nxt = lost_cnt + LOST_W'(1);
      end
    end else begin
      lost_cnt_nxt   = '0;
      track_lost_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1             <= '1;
      s2             <= '1;
      db_cnt         <= '0;
      PathDectSignal <= NO_LINE;
      path_changed   <= 1'b0;
      lost_cnt       <= '0;
      track_lost     <= 1'b0;
    end else begin
      s1             <= sensor_raw;
      s2             <= s1;
      db_cnt         <= db_cnt_nxt;
      PathDectSignal <= path_nxt;
      path_changed   <= (path_nxt != PathDectSignal);
      lost_cnt       <= lost_cnt_nxt;
      track_lost     <= track_lost_nxt;
    end
  end

endmodule

// File: tb/tb_path_sensor_filter.sv
// Directed bench for path_sensor_filter with DEBOUNCE_CYCLES=4, LOST_CYCLES=16;
// expected values are hand-derived edge counts from each input change.
module tb_path_sensor_filter;

  logic       clk;
  logic       rst;
  logic [3:0] sensor_raw;
  logic [3:0] PathDectSignal;
  logic       path_changed;
  logic       track_lost;

  int n_checks;
  int n_fails;

  path_sensor_filter #(
    .DEBOUNCE_CYCLES(4),
    .DB_W           (4),
    .LOST_CYCLES    (16),
    .LOST_W         (5)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor_raw    (sensor_raw),
    .PathDectSignal(PathDectSignal),
    .path_changed  (path_changed),
    .track_lost    (track_lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit before sampling/driving.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] p, input logic pc, input logic tl);
    chk({tag, "_path"}, PathDectSignal, p);
    chk({tag, "_pc"}, {3'b000, path_changed}, {3'b000, pc});
    chk({tag, "_tl"}, {3'b000, track_lost}, {3'b000, tl});
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    rst        = 1'b1;
    sensor_raw = 4'b0000;

    // Reset held 3 cycles with all sensors seeing the line
    tick(1);
    chk_all("rst_during", 4'b1111, 1'b0, 1'b0);
    tick(2);
    chk_all("rst_end", 4'b1111, 1'b0, 1'b0);
    rst = 1'b0;
    tick(1);
    chk_all("rst_after", 4'b1111, 1'b0, 1'b0);
    tick(4);
    chk("rst_e5_path", PathDectSignal, 4'b1111);
    tick(1);
    chk("rst_e6_path", PathDectSignal, 4'b0000);
    chk("rst_e6_pc", {3'b000, path_changed}, 4'b0001);
    tick(1);
    chk("rst_e7_pc", {3'b000, path_changed}, 4'b0000);

    // Lost-track rise from reset release, then glitch rejection
    rst = 1'b1;
    sensor_raw = 4'b1111;
    tick(2);
    rst = 1'b0;
    tick(15);
    chk("lost_e15_tl", {3'b000, track_lost}, 4'b0000);
    tick(1);
    chk("lost_e16_tl", {3'b000, track_lost}, 4'b0001);
    tick(4);
    sensor_raw = 4'b1110;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk_all("glitch_low", 4'b1111, 1'b0, 1'b1);
    end
    sensor_raw = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick(1);
      chk_all("glitch_after", 4'b1111, 1'b0, 1'b1);
    end

    // Stable two-bit change accepted on the 6th edge; track_lost clears next edge
    sensor_raw = 4'b1001;
    tick(5);
    chk("stable_e5_path", PathDectSignal, 4'b1111);
    chk("stable_e5_pc", {3'b000, path_changed}, 4'b0000);
    tick(1);
    chk("stable_e6_path", PathDectSignal, 4'b1001);
    chk("stable_e6_pc", {3'b000, path_changed}, 4'b0001);
    tick(1);
    chk_all("stable_e7", 4'b1001, 1'b0, 1'b0);

    // Bounce on bit 3: low 2, high 1, then low steady
    sensor_raw = 4'b0001;
    tick(1);
    chk_all("bounce_a", 4'b1001, 1'b0, 1'b0);
    tick(1);
    chk_all("bounce_b", 4'b1001, 1'b0, 1'b0);
    sensor_raw = 4'b1001;
    tick(1);
    chk_all("bounce_c", 4'b1001, 1'b0, 1'b0);
    sensor_raw = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_all("bounce_wait", 4'b1001, 1'b0, 1'b0);
    end
    tick(1);
    chk_all("bounce_e6", 4'b0001, 1'b1, 1'b0);
    tick(1);
    chk_all("bounce_e7", 4'b0001, 1'b0, 1'b0);

    // Lost-track then pattern 0111
    rst = 1'b1;
    sensor_raw = 4'b1111;
    tick(2);
    rst = 1'b0;
    tick(16);
    chk("lost2_tl", {3'b000, track_lost}, 4'b0001);
    sensor_raw = 4'b0111;
    tick(5);
    chk("lost2_e5_path", PathDectSignal, 4'b1111);
    chk("lost2_e5_tl", {3'b000, track_lost}, 4'b0001);
    tick(1);
    chk("lost2_e6_path", PathDectSignal, 4'b0111);
    chk("lost2_e6_pc", {3'b000, path_changed}, 4'b0001);
    tick(1);
    chk_all("lost2_e7", 4'b0111, 1'b0, 1'b0);

    // Reset in the middle of a bit-0 debounce discards the partial count
    rst = 1'b1;
    sensor_raw = 4'b1111;
    tick(2);
    rst = 1'b0;
    tick(3);
    sensor_raw = 4'b1110;
    tick(3);
    chk("middb_pre_path", PathDectSignal, 4'b1111);
    rst = 1'b1;
    tick(1);
    chk_all("middb_rst", 4'b1111, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk("middb_wait_path", PathDectSignal, 4'b1111);
      chk("middb_wait_pc", {3'b000, path_changed}, 4'b0000);
    end
    tick(1);
    chk("middb_e6_path", PathDectSignal, 4'b1110);
    chk("middb_e6_pc", {3'b000, path_changed}, 4'b0001);
    tick(1);
    chk("middb_e7_pc", {3'b000, path_changed}, 4'b0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
